// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
// MC_CTRL_SINGLE_STEP_EN adds the PAUSE state used by single-step mode.
package mc_ctrl_pkg;

`ifdef MC_CTRL_SINGLE_STEP_EN
    typedef enum logic [2:0] {
        S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4,
        S_HALTED = 3'd5, S_TRAPPED = 3'd6, S_PAUSE = 3'd7
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4,
        S_HALTED = 3'd5, S_TRAPPED = 3'd6
    } state_t;
`endif

    // Opcode values; the top narrows them to its OPC_W.
    localparam int OPC_NOP   = 0;
    localparam int OPC_ALU_R = 1;
    localparam int OPC_ALU_I = 2;
    localparam int OPC_LD    = 3;
    localparam int OPC_ST    = 4;
    localparam int OPC_BR    = 5;
    localparam int OPC_JMP   = 6;
    localparam int OPC_HALT  = 63;

    localparam int ALU_ADD = 0;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_ILL  = 2'd1;
    localparam logic [1:0] CAUSE_IM   = 2'd2;
    localparam logic [1:0] CAUSE_DM   = 2'd3;

endpackage

// File: rtl/mc_wait_timer.sv
// Ready-wait counter: counts cycles spent waiting and flags the last
// cycle allowed before the sequencer must give up.
module mc_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic atMax
);
    localparam int CW = $clog2(WAIT_MAX + 1);

    logic [CW-1:0] cnt;

    // Count waiting cycles; any state change restarts the count.
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en)    cnt <= cnt + 1'b1;
    end

    // High on the wait cycle that would bring the count to WAIT_MAX.
    assign atMax = (cnt == CW'(WAIT_MAX - 1));

endmodule

// File: rtl/mc_ctrl_seq.sv
// Multi-cycle control sequencer: decodes IR and drives datapath strobes,
// with memory ready handshakes, wait timeout, illegal-opcode trap and a
// saturating retired-instruction counter.
// Optional: MC_CTRL_SINGLE_STEP_EN adds step_req and a PAUSE state.
module mc_ctrl_seq
    import mc_ctrl_pkg::*;
#(
    parameter int OPC_W    = 6,
    parameter int FUNC_W   = 4,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPC_W-1:0]  ir_opcode,
    input  logic [FUNC_W-1:0] ir_func,
    input  logic              zero_flag,
    input  logic              im_ready,
    input  logic              dm_ready,
`ifdef MC_CTRL_SINGLE_STEP_EN
    input  logic              step_req,
`endif
    output logic              load_pc,
    output logic              load_npc,
    output logic              read_im,
    output logic              load_ir,
    output logic              read_reg1,
    output logic              read_reg2,
    output logic              load_a,
    output logic              load_b,
    output logic              load_imm,
    output logic              mux_alu1,
    output logic              mux_alu2,
    output logic              load_alu_out,
    output logic              mux_pc,
    output logic [FUNC_W-1:0] alu_func,
    output logic              read_dm,
    output logic              write_dm,
    output logic              load_lmd,
    output logic              mux_wb,
    output logic              write_reg,
    output logic              halt,
    output logic              trap,
    output logic [1:0]        trap_cause,
    output logic [2:0]        state_o,
    output logic [CNT_W-1:0]  retired
);
    localparam logic [OPC_W-1:0] OP_NOP   = OPC_W'(OPC_NOP);
    localparam logic [OPC_W-1:0] OP_ALU_R = OPC_W'(OPC_ALU_R);
    localparam logic [OPC_W-1:0] OP_ALU_I = OPC_W'(OPC_ALU_I);
    localparam logic [OPC_W-1:0] OP_LD    = OPC_W'(OPC_LD);
    localparam logic [OPC_W-1:0] OP_ST    = OPC_W'(OPC_ST);
    localparam logic [OPC_W-1:0] OP_BR    = OPC_W'(OPC_BR);
    localparam logic [OPC_W-1:0] OP_JMP   = OPC_W'(OPC_JMP);
    localparam logic [OPC_W-1:0] OP_HALT  = OPC_W'(OPC_HALT);
    localparam logic [FUNC_W-1:0] FN_ADD  = FUNC_W'(ALU_ADD);

`ifdef MC_CTRL_SINGLE_STEP_EN
    localparam state_t RET_STATE   = S_PAUSE;
    localparam state_t RESET_STATE = S_PAUSE;
`else
    localparam state_t RET_STATE   = S_IF;
    localparam state_t RESET_STATE = S_IF;
`endif

    state_t     state, stateNext;
    logic       retire, waitEn, waitAtMax;
    logic [1:0] causeNext;

    mc_wait_timer #(.WAIT_MAX(WAIT_MAX)) uWait (
        .clk   (clk),
        .rst   (rst),
        .clr   (stateNext != state),
        .en    (waitEn),
        .atMax (waitAtMax)
    );

    // State register plus sticky status and the saturating retire count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RESET_STATE;
            halt       <= 1'b0;
            trap       <= 1'b0;
            trap_cause <= CAUSE_NONE;
            retired    <= '0;
        end else begin
            state <= stateNext;
            if (stateNext == S_HALTED) halt <= 1'b1;
            if (stateNext == S_TRAPPED && state != S_TRAPPED) begin
                trap       <= 1'b1;
                trap_cause <= causeNext;
            end
            if (retire && retired != '1) retired <= retired + 1'b1;
        end
    end

    // Next state and strobes; everything is held at 0 while rst is high.
    always_comb begin
        stateNext    = state;
        causeNext    = CAUSE_NONE;
        retire       = 1'b0;
        waitEn       = 1'b0;
        load_pc      = 1'b0;
        load_npc     = 1'b0;
        read_im      = 1'b0;
        load_ir      = 1'b0;
        read_reg1    = 1'b0;
        read_reg2    = 1'b0;
        load_a       = 1'b0;
        load_b       = 1'b0;
        load_imm     = 1'b0;
        mux_alu1     = 1'b0;
        mux_alu2     = 1'b0;
        load_alu_out = 1'b0;
        mux_pc       = 1'b0;
        alu_func     = '0;
        read_dm      = 1'b0;
        write_dm     = 1'b0;
        load_lmd     = 1'b0;
        mux_wb       = 1'b0;
        write_reg    = 1'b0;
        if (!rst) begin
            case (state)
                S_IF: begin
                    read_im = 1'b1;
                    if (im_ready) begin
                        load_ir   = 1'b1;
                        load_npc  = 1'b1;
                        stateNext = S_ID;
                    end else begin
                        waitEn = 1'b1;
                        if (waitAtMax) begin
                            stateNext = S_TRAPPED;
                            causeNext = CAUSE_IM;
                        end
                    end
                end
                S_ID: begin
                    read_reg1 = 1'b1;
                    read_reg2 = 1'b1;
                    load_a    = 1'b1;
                    load_b    = 1'b1;
                    load_imm  = 1'b1;
                    case (ir_opcode)
                        OP_NOP: begin
                            load_pc   = 1'b1;
                            retire    = 1'b1;
                            stateNext = RET_STATE;
                        end
                        OP_HALT: begin
                            retire    = 1'b1;
                            stateNext = S_HALTED;
                        end
                        OP_ALU_R, OP_ALU_I, OP_LD, OP_ST, OP_BR, OP_JMP:
                            stateNext = S_EX;
                        default: begin
                            stateNext = S_TRAPPED;
                            causeNext = CAUSE_ILL;
                        end
                    endcase
                end
                S_EX: begin
                    load_alu_out = 1'b1;
                    stateNext    = S_MEM;
                    case (ir_opcode)
                        OP_ALU_R: begin
                            alu_func  = ir_func;
                            stateNext = S_WB;
                        end
                        OP_ALU_I: begin
                            mux_alu2  = 1'b1;
                            alu_func  = ir_func;
                            stateNext = S_WB;
                        end
                        OP_LD, OP_ST: begin
                            mux_alu2 = 1'b1;
                            alu_func = FN_ADD;
                        end
                        OP_BR, OP_JMP: begin
                            mux_alu1 = 1'b1;
                            mux_alu2 = 1'b1;
                            alu_func = FN_ADD;
                        end
                        // IR changed under us: treat as illegal.
                        default: begin
                            stateNext = S_TRAPPED;
                            causeNext = CAUSE_ILL;
                        end
                    endcase
                end
                S_MEM: begin
                    case (ir_opcode)
                        OP_LD: begin
                            read_dm = 1'b1;
                            if (dm_ready) begin
                                load_lmd  = 1'b1;
                                stateNext = S_WB;
                            end else begin
                                waitEn = 1'b1;
                                if (waitAtMax) begin
                                    stateNext = S_TRAPPED;
                                    causeNext = CAUSE_DM;
                                end
                            end
                        end
                        OP_ST: begin
                            write_dm = 1'b1;
                            if (dm_ready) begin
                                load_pc   = 1'b1;
                                retire    = 1'b1;
                                stateNext = RET_STATE;
                            end else begin
                                waitEn = 1'b1;
                                if (waitAtMax) begin
                                    stateNext = S_TRAPPED;
                                    causeNext = CAUSE_DM;
                                end
                            end
                        end
                        OP_BR, OP_JMP: begin
                            load_pc   = 1'b1;
                            mux_pc    = (ir_opcode == OP_JMP) || zero_flag;
                            retire    = 1'b1;
                            stateNext = RET_STATE;
                        end
                        default: begin
                            stateNext = S_TRAPPED;
                            causeNext = CAUSE_ILL;
                        end
                    endcase
                end
                S_WB: begin
                    write_reg = 1'b1;
                    mux_wb    = (ir_opcode == OP_LD);
                    load_pc   = 1'b1;
                    retire    = 1'b1;
                    stateNext = RET_STATE;
                end
`ifdef MC_CTRL_SINGLE_STEP_EN
                S_PAUSE: begin
                    if (step_req) stateNext = S_IF;
                end
`endif
                default: stateNext = state;   // HALTED / TRAPPED absorb
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_mc_ctrl_seq.sv
// Directed bench for mc_ctrl_seq: instruction latencies, branch PC select,
// memory wait, timeout/illegal traps, reset abort and retire saturation.
module tb_mc_ctrl_seq;
    localparam int OPC_W    = 6;
    localparam int FUNC_W   = 4;
    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [OPC_W-1:0]  ir_opcode = '0;
    logic [FUNC_W-1:0] ir_func = '0;
    logic              zero_flag = 1'b0;
    logic              im_ready = 1'b1;
    logic              dm_ready = 1'b1;
    logic load_pc, load_npc, read_im, load_ir, read_reg1, read_reg2, load_a, load_b, load_imm;
    logic mux_alu1, mux_alu2, load_alu_out, mux_pc, read_dm, write_dm, load_lmd, mux_wb, write_reg;
    logic [FUNC_W-1:0] alu_func;
    logic              halt, trap;
    logic [1:0]        trap_cause;
    logic [2:0]        state_o;
    logic [CNT_W-1:0]  retired;

    int passCnt = 0;
    int totalCnt = 0;

    wire [17:0] strobes = {load_pc, load_npc, read_im, load_ir, read_reg1, read_reg2, load_a,
                           load_b, load_imm, mux_alu1, mux_alu2, load_alu_out, mux_pc,
                           read_dm, write_dm, load_lmd, mux_wb, write_reg};

    mc_ctrl_seq #(.OPC_W(OPC_W), .FUNC_W(FUNC_W), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ir_opcode(ir_opcode), .ir_func(ir_func), .zero_flag(zero_flag),
        .im_ready(im_ready), .dm_ready(dm_ready),
        .load_pc(load_pc), .load_npc(load_npc), .read_im(read_im), .load_ir(load_ir),
        .read_reg1(read_reg1), .read_reg2(read_reg2), .load_a(load_a), .load_b(load_b),
        .load_imm(load_imm), .mux_alu1(mux_alu1), .mux_alu2(mux_alu2),
        .load_alu_out(load_alu_out), .mux_pc(mux_pc), .alu_func(alu_func),
        .read_dm(read_dm), .write_dm(write_dm), .load_lmd(load_lmd), .mux_wb(mux_wb),
        .write_reg(write_reg), .halt(halt), .trap(trap), .trap_cause(trap_cause),
        .state_o(state_o), .retired(retired)
    );

    always #5 clk = ~clk;

    // Two clock edges of reset; returns at a negedge with rst just released.
    task automatic doReset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); @(negedge clk); rst = 1'b0;
    endtask

    // Issue one instruction from IF and count cycles until IF is re-entered.
    task automatic runInstr(input logic [OPC_W-1:0] opc, input logic [FUNC_W-1:0] fn,
                            input logic z, output int cyc, output logic [FUNC_W-1:0] exFunc,
                            output logic memLoadPc, output logic memMuxPc);
        ir_opcode = opc; ir_func = fn; zero_flag = z;
        cyc = 0; exFunc = '1; memLoadPc = 1'b0; memMuxPc = 1'b0;
        do begin
            #1;
            if (state_o == 3'd2) exFunc = alu_func;
            if (state_o == 3'd3) begin memLoadPc = load_pc; memMuxPc = mux_pc; end
            @(negedge clk);
            cyc++;
        end while (state_o != 3'd0 && cyc < 20);
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        totalCnt++; if (state_o !== 3'd0) $display("FAIL reset_state got %0d want 0", state_o); else passCnt++;
        totalCnt++; if (strobes !== 18'd0 || alu_func !== 4'd0) $display("FAIL reset_strobes got %h/%h want 0/0", strobes, alu_func); else passCnt++;
        totalCnt++; if ({halt, trap, trap_cause} !== 4'd0 || retired !== 3'd0) $display("FAIL reset_status got %b ret %0d want 0", {halt, trap, trap_cause}, retired); else passCnt++;
        rst = 1'b0; #1;
        totalCnt++; if (read_im !== 1'b1 || load_ir !== 1'b1) $display("FAIL reset_fetch got read_im %b load_ir %b want 1 1", read_im, load_ir); else passCnt++;
    endtask

    task automatic test_stream();
        int c; logic [FUNC_W-1:0] f; logic lp, mp;
        doReset();
        runInstr(6'd1, 4'd5, 1'b0, c, f, lp, mp);
        totalCnt++; if (c !== 4) $display("FAIL alu_r_cycles got %0d want 4", c); else passCnt++;
        totalCnt++; if (f !== 4'd5) $display("FAIL alu_r_func got %0d want 5", f); else passCnt++;
        runInstr(6'd3, 4'd9, 1'b0, c, f, lp, mp);
        totalCnt++; if (c !== 5) $display("FAIL ld_cycles got %0d want 5", c); else passCnt++;
        totalCnt++; if (f !== 4'd0) $display("FAIL ld_func got %0d want 0", f); else passCnt++;
        runInstr(6'd4, 4'd9, 1'b0, c, f, lp, mp);
        totalCnt++; if (c !== 4) $display("FAIL st_cycles got %0d want 4", c); else passCnt++;
        runInstr(6'd0, 4'd0, 1'b0, c, f, lp, mp);
        totalCnt++; if (c !== 2) $display("FAIL nop_cycles got %0d want 2", c); else passCnt++;
        ir_opcode = 6'd63;
        @(negedge clk); @(negedge clk); #1;
        totalCnt++; if (halt !== 1'b1 || state_o !== 3'd5 || trap !== 1'b0) $display("FAIL halt_state got halt %b state %0d trap %b want 1 5 0", halt, state_o, trap); else passCnt++;
        totalCnt++; if (retired !== 3'd5) $display("FAIL halt_retired got %0d want 5", retired); else passCnt++;
        totalCnt++; if (strobes !== 18'd0) $display("FAIL halt_strobes got %h want 0", strobes); else passCnt++;
    endtask

    task automatic test_branch();
        int c; logic [FUNC_W-1:0] f; logic lp, mp;
        doReset();
        runInstr(6'd5, 4'd0, 1'b1, c, f, lp, mp);
        totalCnt++; if ({lp, mp} !== 2'b11 || c !== 4) $display("FAIL br_taken got lp %b mux %b cyc %0d want 1 1 4", lp, mp, c); else passCnt++;
        runInstr(6'd5, 4'd0, 1'b0, c, f, lp, mp);
        totalCnt++; if ({lp, mp} !== 2'b10) $display("FAIL br_not_taken got lp %b mux %b want 1 0", lp, mp); else passCnt++;
        runInstr(6'd6, 4'd0, 1'b0, c, f, lp, mp);
        totalCnt++; if ({lp, mp} !== 2'b11 || c !== 4) $display("FAIL jmp got lp %b mux %b cyc %0d want 1 1 4", lp, mp, c); else passCnt++;
        for (int i = 0; i < 4; i++) runInstr(6'd0, 4'd0, 1'b0, c, f, lp, mp);
        totalCnt++; if (retired !== 3'd7) $display("FAIL retired_max got %0d want 7", retired); else passCnt++;
        runInstr(6'd0, 4'd0, 1'b0, c, f, lp, mp);
        totalCnt++; if (retired !== 3'd7) $display("FAIL retired_saturate got %0d want 7", retired); else passCnt++;
    endtask

    task automatic test_ld_wait();
        int rdCnt = 0; int lmdCnt = 0;
        doReset();
        ir_opcode = 6'd3; dm_ready = 1'b0;
        for (int i = 0; i < 10 && state_o != 3'd3; i++) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dm_ready = 1'b1;
            #1;
            rdCnt += int'(read_dm);
            lmdCnt += int'(load_lmd);
            @(negedge clk);
        end
        totalCnt++; if (rdCnt !== 4) $display("FAIL ld_wait_read_dm got %0d want 4", rdCnt); else passCnt++;
        totalCnt++; if (lmdCnt !== 1) $display("FAIL ld_wait_lmd got %0d want 1", lmdCnt); else passCnt++;
        #1;
        totalCnt++; if (state_o !== 3'd4 || {write_reg, mux_wb} !== 2'b11) $display("FAIL ld_wb got state %0d wr/wb %b want 4 11", state_o, {write_reg, mux_wb}); else passCnt++;
    endtask

    task automatic test_im_timeout();
        doReset();
        ir_opcode = 6'd0; im_ready = 1'b0;
        repeat (14) @(negedge clk);
        totalCnt++; if (state_o !== 3'd0 || trap !== 1'b0) $display("FAIL im_wait_early got state %0d trap %b want 0 0", state_o, trap); else passCnt++;
        @(negedge clk);
        totalCnt++; if (state_o !== 3'd6 || trap !== 1'b1 || trap_cause !== 2'd2) $display("FAIL im_timeout got state %0d trap %b cause %0d want 6 1 2", state_o, trap, trap_cause); else passCnt++;
        totalCnt++; if (strobes !== 18'd0) $display("FAIL im_timeout_strobes got %h want 0", strobes); else passCnt++;
        im_ready = 1'b1;
        repeat (3) @(negedge clk);
        totalCnt++; if (state_o !== 3'd6 || strobes !== 18'd0 || trap_cause !== 2'd2) $display("FAIL trap_absorb got state %0d strobes %h cause %0d want 6 0 2", state_o, strobes, trap_cause); else passCnt++;
    endtask

    task automatic test_im_late_ready();
        doReset();
        ir_opcode = 6'd0; im_ready = 1'b0;
        repeat (14) @(negedge clk);
        im_ready = 1'b1; #1;
        totalCnt++; if (load_ir !== 1'b1 || trap !== 1'b0) $display("FAIL late_ready_load_ir got %b trap %b want 1 0", load_ir, trap); else passCnt++;
        @(negedge clk);
        totalCnt++; if (state_o !== 3'd1 || trap !== 1'b0) $display("FAIL late_ready_state got %0d trap %b want 1 0", state_o, trap); else passCnt++;
    endtask

    task automatic test_illegal();
        doReset();
        ir_opcode = 6'd7;
        repeat (2) @(negedge clk);
        totalCnt++; if (state_o !== 3'd6 || trap !== 1'b1 || trap_cause !== 2'd1) $display("FAIL illegal got state %0d trap %b cause %0d want 6 1 1", state_o, trap, trap_cause); else passCnt++;
    endtask

    task automatic test_rst_mid();
        doReset();
        ir_opcode = 6'd4; dm_ready = 1'b0;
        repeat (3) @(negedge clk); #1;
        totalCnt++; if (write_dm !== 1'b1 || state_o !== 3'd3) $display("FAIL st_mem got write_dm %b state %0d want 1 3", write_dm, state_o); else passCnt++;
        rst = 1'b1;
        @(negedge clk);
        totalCnt++; if (write_dm !== 1'b0 || state_o !== 3'd0 || retired !== 3'd0) $display("FAIL rst_abort got write_dm %b state %0d ret %0d want 0 0 0", write_dm, state_o, retired); else passCnt++;
        rst = 1'b0; dm_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_branch();
        test_ld_wait();
        test_im_timeout();
        test_im_late_ready();
        test_illegal();
        test_rst_mid();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mc_ctrl_seq.md
Name: mc_ctrl_seq

Overview:
Parametrised multi-cycle control sequencer. It is the successor to the fixed control unit that drives the processor datapath strobes.
- Adds an opcode/ALU-function width generalisation.
- Adds ready-handshakes to instruction and data memory, with a bounded wait timeout.
- Adds an illegal-opcode trap and a retired-instruction counter.
- Sits between the IR output of the datapath and every load/read/write/mux strobe of the datapath, inside the processor top level.

Parameters:
OPC_W, 6, opcode field width
FUNC_W, 4, ALU function width; also the width of the function field from IR
WAIT_MAX, 15, maximum cycles spent waiting on a ready before trapping; must be at least 1
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ir_opcode  in  OPC_W  opcode field of IR
ir_func  in  FUNC_W  function field of IR; passed to alu_func for ALU_R
zero_flag  in  1  branch condition from datapath
im_ready  in  1  instruction memory data valid
dm_ready  in  1  data memory access complete
load_pc, load_npc, read_im, load_ir  out  1  fetch strobes
read_reg1, read_reg2, load_a, load_b, load_imm  out  1  decode strobes
mux_alu1, mux_alu2, load_alu_out, mux_pc  out  1  execute/PC strobes
alu_func  out  FUNC_W  ALU operation
read_dm, write_dm, load_lmd, mux_wb, write_reg  out  1  memory/write-back strobes
halt  out  1  sticky halted
trap  out  1  sticky trap (illegal opcode or timeout)
trap_cause  out  2  0 none, 1 illegal opcode, 2 IM timeout, 3 DM timeout
state_o  out  3  current state encoding (debug)
retired  out  CNT_W  count of retired instructions, saturating

Behaviour:
- Reset values: state=IF; all strobes 0; alu_func=0; halt=0; trap=0; trap_cause=0; retired=0; wait counter=0. Reset mid-operation aborts the instruction with no write strobes.
- States: IF, ID, EX, MEM, WB, HALTED, TRAPPED. Strobes are combinational from state and inputs. Every strobe not listed for a state is 0.
- IF
  - Drives read_im=1.
  - If im_ready=1: load_ir=1, load_npc=1, next state ID.
  - Otherwise stay in IF and increment the wait counter.
- ID
  - Drives read_reg1, read_reg2, load_a, load_b, load_imm.
  - Decodes ir_opcode:
    - NOP: load_pc=1 (mux_pc=0), retire, go to IF.
    - HALT: go to HALTED; this counts as a retire.
    - Unknown opcode: go to TRAPPED with cause 1.
    - Any other valid opcode: go to EX.
- EX
  - Always drives load_alu_out=1.
  - ALU_R: mux_alu1=0, mux_alu2=0, alu_func=ir_func.
  - ALU_I, LD, ST: mux_alu2=1, alu_func=ADD for LD/ST, alu_func=ir_func for ALU_I.
  - BR, JMP: mux_alu1=1 (NPC), mux_alu2=1, alu_func=ADD.
  - Next state: WB for ALU_R/ALU_I; MEM for all others.
- MEM
  - LD: read_dm=1. When dm_ready=1: load_lmd=1, go to WB.
  - ST: write_dm=1. When dm_ready=1: load_pc=1, retire, go to IF.
  - While dm_ready=0 in LD/ST: stay in MEM and increment the wait counter.
  - BR/JMP: load_pc=1, mux_pc=(JMP or zero_flag), retire, go to IF. No wait.
- WB
  - write_reg=1, mux_wb=1 for LD and 0 for ALU.
  - load_pc=1, mux_pc=0, retire, go to IF.
- Latency with ready tied high:
  - NOP: 2 cycles.
  - ALU, ST, BR, JMP: 4 cycles.
  - LD: 5 cycles.
- Wait counter
  - Cleared on every state change.
  - Reaching WAIT_MAX while still waiting → TRAPPED with cause 2 (IF) or 3 (MEM).
  - A ready arriving in the same cycle the count hits WAIT_MAX wins; no trap.
- HALTED and TRAPPED are absorbing; only rst leaves them. All strobes are 0. halt or trap is held at 1.
- Retire: retired increments by 1 per retire and saturates at all-ones with no wrap.
- The opcode is sampled from ir_opcode in every state. The datapath holds IR stable from load_ir until the next IF.

Optional Feature:
MC_CTRL_SINGLE_STEP_EN
- Defined: adds input step_req (1 bit) and state PAUSE.
  - After each retire, go to PAUSE instead of IF.
  - PAUSE → IF on a cycle with step_req=1; all strobes are 0 in PAUSE.
  - Out of reset, start in PAUSE.
- Undefined: no port, no state; behaviour exactly as above.

Decomposition:
- Package mc_ctrl_pkg holds:
  - State enum.
  - Opcode constants: NOP=0, ALU_R=1, ALU_I=2, LD=3, ST=4, BR=5, JMP=6, HALT=63 (as OPC_W-bit values).
  - ALU_ADD=0.
  - trap_cause codes.
- Sub-module mc_wait_timer: a clear/enable counter with a WAIT_MAX compare, instantiated once.

Test Plan:
- Reset, then a stream ALU_R(func=5), LD, ST, NOP, HALT with readies high:
  - 4, 5, 4, 2 cycles between IF entries; alu_func=5 in EX of ALU_R.
  - After HALT: halt=1, retired=5.
- BR with zero_flag=1, then BR with zero_flag=0: MEM cycle shows load_pc=1 with mux_pc=1, then load_pc=1 with mux_pc=0.
- LD with dm_ready held low 3 cycles: read_dm stays 1 for 4 cycles; load_lmd pulses once in the cycle dm_ready=1.
- im_ready low for WAIT_MAX (15) cycles: trap=1, trap_cause=2, all strobes 0 until rst.
- Same with im_ready rising on the 15th cycle: no trap; load_ir=1.
- Opcode 7 in ID: trap_cause=1. Assert rst during MEM of ST: write_dm=0 the next cycle and state=IF.
